// File: rtl/spad_pkg.sv
// spad_pkg: shared types and constants for the scratchpad stream writer.
//   spad_state_e  - writer FSM states
//   SpadDataW     - default stream / scratchpad word width
//   SpadDepth     - default scratchpad depth in words
//   even_parity() - even parity of a word (zero-extended to SpadParityMaxW bits)
package spad_pkg;

    localparam int unsigned SpadDataW      = 16;
    localparam int unsigned SpadDepth      = 16;
    // Widest word the parity helper accepts; zero-extension does not change parity.
    localparam int unsigned SpadParityMaxW = 64;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StDone = 2'd2,
        StOvf  = 2'd3
    } spad_state_e;

    function automatic logic even_parity(input logic [SpadParityMaxW-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/spad_ptr_ctr.sv
// spad_ptr_ctr: circular tail pointer and occupancy counter for one scratchpad.
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   inc  - one word written this cycle (advances tail, raises occupancy)
//   dec  - consumer frees one word this cycle (ignored when empty)
//   tail - next write address, wraps modulo DEPTH
//   used - current occupancy, 0..DEPTH
module spad_ptr_ctr
    import spad_pkg::*;
#(
    parameter int unsigned DEPTH  = SpadDepth,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    output logic [ADDR_W-1:0] tail,
    output logic [ADDR_W:0]   used
);

    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [ADDR_W:0]   used_q, used_d;
    logic              dec_eff;

    always_comb begin
        dec_eff = dec & (used_q != '0);
        tail_d  = tail_q;
        used_d  = used_q;
        // DEPTH is a power of two, so natural wrap of the ADDR_W-bit pointer is mod DEPTH.
        if (inc) begin
            tail_d = tail_q + ADDR_W'(1);
        end
        // Simultaneous inc and dec cancel out.
        unique case ({inc, dec_eff})
            2'b10:   used_d = used_q + (ADDR_W + 1)'(1);
            2'b01:   used_d = used_q - (ADDR_W + 1)'(1);
            default: used_d = used_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tail_q <= '0;
            used_q <= '0;
        end else begin
            tail_q <= tail_d;
            used_q <= used_d;
        end
    end

    assign tail = tail_q;
    assign used = used_q;

endmodule

// File: rtl/spad_stream_writer.sv
// spad_stream_writer: writes one row of row_len stream words into a circular
// scratchpad, then flags done (sticky) or full on overflow (sticky).
//   clk, rst            - clock, asynchronous active-high reset
//   en                  - transfer enable; a rising edge starts a transfer
//   row_len             - words per transfer, sampled at start
//   in_valid/in_data    - input stream, in_ready accepts
//   rel                 - consumer frees one scratchpad word
//   wr_en/wr_addr/wr_data - registered scratchpad write port
//   head_addr           - tail pointer latched at transfer start
//   used                - scratchpad occupancy
//   done, full          - sticky completion / overflow abort
// Build option: SPAD_WR_PARITY_EN widens wr_data by one bit carrying even parity.
module spad_stream_writer
    import spad_pkg::*;
#(
    parameter int unsigned DATA_W = SpadDataW,
    parameter int unsigned DEPTH  = SpadDepth,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W:0]   row_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              rel,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
`ifdef SPAD_WR_PARITY_EN
    output logic [DATA_W:0]   wr_data,
`else
    output logic [DATA_W-1:0] wr_data,
`endif
    output logic [ADDR_W-1:0] head_addr,
    output logic [ADDR_W:0]   used,
    output logic              done,
    output logic              full
);

`ifdef SPAD_WR_PARITY_EN
    localparam int unsigned WrDataW = DATA_W + 1;
`else
    localparam int unsigned WrDataW = DATA_W;
`endif
    localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

    spad_state_e        state_q, state_d;
    logic               en_q;
    logic [ADDR_W:0]    row_len_q, row_len_d;
    logic [ADDR_W:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]  head_q, head_d;
    logic               done_q, done_d;
    logic               full_q, full_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [WrDataW-1:0] wr_data_q, wr_data_d;

    logic [ADDR_W-1:0]  tail;
    logic               start;
    logic               accept;
    logic               is_full;

    spad_ptr_ctr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ptr_ctr (
        .clk  (clk),
        .rst  (rst),
        .inc  (accept),
        .dec  (rel),
        .tail (tail),
        .used (used)
    );

    assign start   = en & ~en_q;
    assign is_full = (used == DepthW);
    // A zero-length row must not accept anything on its way to DONE.
    assign in_ready = (state_q == StFill) & (row_len_q != '0) & ~is_full;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        row_len_d = row_len_q;
        cnt_d     = cnt_q;
        head_d    = head_q;
        done_d    = done_q;
        full_d    = full_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (accept) begin
            wr_en_d   = 1'b1;
            wr_addr_d = tail;
`ifdef SPAD_WR_PARITY_EN
            wr_data_d = {even_parity(SpadParityMaxW'(in_data)), in_data};
`else
            wr_data_d = in_data;
`endif
            cnt_d     = cnt_q + (ADDR_W + 1)'(1);
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    row_len_d = row_len;
                    head_d    = tail;
                    cnt_d     = '0;
                    done_d    = 1'b0;
                    full_d    = 1'b0;
                    state_d   = StFill;
                end
            end
            StFill: begin
                if (row_len_q == '0) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (accept) begin
                    // The last beat completes the row even if en drops with it.
                    if (cnt_q == row_len_q - (ADDR_W + 1)'(1)) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else if (!en) begin
                        state_d = StIdle;
                    end
                end else if (is_full && in_valid) begin
                    full_d  = 1'b1;
                    state_d = StOvf;
                end else if (!en) begin
                    state_d = StIdle;
                end
            end
            StOvf: begin
                if (!en) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            en_q      <= 1'b0;
            row_len_q <= '0;
            cnt_q     <= '0;
            head_q    <= '0;
            done_q    <= 1'b0;
            full_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en;
            row_len_q <= row_len_d;
            cnt_q     <= cnt_d;
            head_q    <= head_d;
            done_q    <= done_d;
            full_q    <= full_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign head_addr = head_q;
    assign done      = done_q;
    assign full      = full_q;

endmodule

// File: tb/tb_spad_stream_writer.sv
// Bench for spad_stream_writer: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized transfers.
module tb_spad_stream_writer;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
`ifdef SPAD_WR_PARITY_EN
    localparam int WD = 17;
`else
    localparam int WD = 16;
`endif
    localparam int MIdle = 0;
    localparam int MFill = 1;
    localparam int MDone = 2;
    localparam int MOvf  = 3;

    logic              clk;
    logic              rst;
    logic              en;
    logic [ADDR_W:0]   row_len;
    logic              in_valid;
    logic [15:0]       in_data;
    logic              in_ready;
    logic              rel;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WD-1:0]     wr_data;
    logic [ADDR_W-1:0] head_addr;
    logic [ADDR_W:0]   used;
    logic              done;
    logic              full;

    spad_stream_writer #(
        .DATA_W (16),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .row_len   (row_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .rel       (rel),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .head_addr (head_addr),
        .used      (used),
        .done      (done),
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int log_addr[$];
    int log_data[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [WD-1:0] model_word(input logic [15:0] d);
`ifdef SPAD_WR_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    // ---------------- reference model ----------------
    int            m_mode, m_tail, m_used, m_left, m_head;
    logic          m_done, m_full, m_en_prev, m_wr;
    int            m_wr_addr;
    logic [WD-1:0] m_wr_data;
    logic          m_ready, m_acc, m_rlv, m_rise;

    assign m_ready = (m_mode == MFill) && (m_left != 0) && (m_used < DEPTH);
    assign m_acc   = m_ready && in_valid;
    assign m_rlv   = rel && (m_used > 0);
    assign m_rise  = en && !m_en_prev;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= MIdle; m_tail <= 0; m_used <= 0; m_left <= 0; m_head <= 0;
            m_done <= 1'b0; m_full <= 1'b0; m_en_prev <= 1'b0; m_wr <= 1'b0;
            m_wr_addr <= 0; m_wr_data <= '0;
        end else begin
            m_wr <= m_acc;
            if (m_acc) begin
                m_wr_addr <= m_tail;
                m_wr_data <= model_word(in_data);
                m_tail    <= (m_tail + 1) % DEPTH;
            end
            m_used    <= m_used + (m_acc ? 1 : 0) - (m_rlv ? 1 : 0);
            m_en_prev <= en;
            case (m_mode)
                MIdle, MDone: begin
                    if (m_rise) begin
                        m_mode <= MFill; m_left <= int'(row_len); m_head <= m_tail;
                        m_done <= 1'b0; m_full <= 1'b0;
                    end
                end
                MFill: begin
                    if (m_left == 0) begin
                        m_mode <= MDone; m_done <= 1'b1;
                    end else if (m_acc) begin
                        m_left <= m_left - 1;
                        if (m_left == 1) begin
                            m_mode <= MDone; m_done <= 1'b1;
                        end else if (!en) begin
                            m_mode <= MIdle;
                        end
                    end else if (m_used == DEPTH && in_valid) begin
                        m_mode <= MOvf; m_full <= 1'b1;
                    end else if (!en) begin
                        m_mode <= MIdle;
                    end
                end
                MOvf: if (!en) m_mode <= MIdle;
                default: m_mode <= MIdle;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("in_ready", 32'(in_ready), 32'(m_ready));
            check("wr_en", 32'(wr_en), 32'(m_wr));
            if (m_wr) begin
                check("wr_addr", 32'(wr_addr), m_wr_addr);
                check("wr_data", 32'(wr_data), 32'(m_wr_data));
            end
            check("head_addr", 32'(head_addr), m_head);
            check("used", 32'(used), m_used);
            check("done", 32'(done), 32'(m_done));
            check("full", 32'(full), 32'(m_full));
            if (wr_en) begin
                log_addr.push_back(int'(wr_addr));
                log_data.push_back(int'(wr_data[15:0]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start(input int len);
        @(negedge clk); en = 1'b0; in_valid = 1'b0; rel = 1'b0;
        @(negedge clk); en = 1'b1; row_len = (ADDR_W + 1)'(len);
    endtask

    task automatic send(input logic [15:0] d, input logic r);
        @(negedge clk); in_valid = 1'b1; in_data = d; rel = r;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); in_valid = 1'b0; rel = r;
        end
    endtask

    task automatic check_log(input string nm, input int first_addr, input int n);
        check({nm, "_count"}, log_addr.size(), n);
        for (int i = 0; i < n && i < log_addr.size(); i++)
            check({nm, "_addr"}, log_addr[i], (first_addr + i) % DEPTH);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        en = 1'b0; row_len = '0; in_valid = 1'b0; in_data = '0; rel = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_used", 32'(used), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Basic row of four back-to-back words.
        start(4);
        send(16'h0011, 1'b0); send(16'h0022, 1'b0); send(16'h0033, 1'b0); send(16'h0044, 1'b0);
        idle(1, 1'b0);
        check("t1_last_wr_en", 32'(wr_en), 1);
        check("t1_done_with_last", 32'(done), 1);
        check("t1_last_data", 32'(wr_data[15:0]), 32'h44);
        idle(2, 1'b0);
        check("t1_used", 32'(used), 4);
        check("t1_in_ready", 32'(in_ready), 0);
        check("t1_model_used", m_used, 4);
        check_log("t1", 0, 4);
        if (log_data.size() >= 2) check("t1_data1", log_data[1], 32'h22);
        log_addr.delete(); log_data.delete();

        // Follow-up row appends after the first.
        start(3);
        send(16'h00a1, 1'b0); send(16'h00a2, 1'b0); send(16'h00a3, 1'b0);
        idle(3, 1'b0);
        check("t2_head", 32'(head_addr), 4);
        check("t2_used", 32'(used), 7);
        check_log("t2", 4, 3);
        log_addr.delete(); log_data.delete();

        // Advance tail to 14 with matched releases, then a wrapping row.
        start(7);
        for (int i = 0; i < 7; i++) send(16'(16'h0100 + i), 1'b1);
        idle(3, 1'b0);
        check("t3a_used", 32'(used), 7);
        log_addr.delete(); log_data.delete();
        start(4);
        for (int i = 0; i < 4; i++) send(16'(16'h0200 + i), 1'b1);
        idle(3, 1'b0);
        check("t3_head", 32'(head_addr), 14);
        check("t3_done", 32'(done), 1);
        check("t3_used", 32'(used), 7);
        check_log("t3", 14, 4);
        log_addr.delete(); log_data.delete();

        // Accept with release at used==5, then release at empty.
        idle(2, 1'b1);
        start(1);
        send(16'h0555, 1'b1);
        idle(2, 1'b0);
        check("t4_used_5", 32'(used), 5);
        idle(5, 1'b1);
        idle(4, 1'b1);
        idle(1, 1'b0);
        check("t4_used_0", 32'(used), 0);
        log_addr.delete(); log_data.delete();

        // Overflow: sixteen accepted, seventeenth refused.
        start(20);
        for (int i = 0; i < 17; i++) send(16'(16'h0300 + i), 1'b0);
        idle(1, 1'b0);
        check("t5_full", 32'(full), 1);
        check("t5_no_wr", 32'(wr_en), 0);
        check("t5_used", 32'(used), 16);
        idle(3, 1'b0);
        check("t5_full_held", 32'(full), 1);
        @(negedge clk); en = 1'b0;
        idle(2, 1'b0);
        check("t5_full_after_idle", 32'(full), 1);
        check("t5_model_idle", m_mode, MIdle);
        check_log("t5", 3, 16);
        idle(16, 1'b1);
        idle(1, 1'b0);
        log_addr.delete(); log_data.delete();

        // Zero-length row.
        start(0);
        idle(3, 1'b0);
        check("t7_done", 32'(done), 1);
        check("t7_no_writes", log_addr.size(), 0);

        // Reset in the middle of a transfer.
        start(4);
        send(16'h0aa1, 1'b0); send(16'h0aa2, 1'b0);
        @(negedge clk); in_valid = 1'b0; en = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("t6_in_ready", 32'(in_ready), 0);
        check("t6_wr_en", 32'(wr_en), 0);
        check("t6_wr_addr", 32'(wr_addr), 0);
        check("t6_wr_data", 32'(wr_data), 0);
        check("t6_head", 32'(head_addr), 0);
        check("t6_used", 32'(used), 0);
        check("t6_done", 32'(done), 0);
        check("t6_full", 32'(full), 0);
        @(negedge clk); rst = 1'b0;
        log_addr.delete(); log_data.delete();
        start(4);
        for (int i = 0; i < 4; i++) send(16'(16'h0b00 + i), 1'b0);
        idle(2, 1'b0);
        check_log("t6_after", 0, 4);
        log_addr.delete(); log_data.delete();

        // Randomized transfers with random stalls, releases and aborts.
        for (int t = 0; t < 80; t++) begin
            start(int'($urandom_range(0, 9)));
            for (int c = 0; c < 80; c++) begin
                @(negedge clk);
                in_valid = ($urandom_range(0, 9) < 7);
                in_data  = 16'($urandom);
                rel      = ($urandom_range(0, 9) < 4);
                if (m_mode == MOvf || $urandom_range(0, 49) == 0) en = 1'b0;
                if (m_mode == MIdle || (m_mode == MDone && c > 3)) break;
            end
        end
        idle(3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spad_stream_writer.md
# spad_stream_writer

Write-side engine for the input-feature / filter scratchpads of the convolution accelerator. When enabled by the main controller, it accepts a valid/ready word stream and writes one row of `row_len` words into a circular scratchpad at consecutive addresses. It then reports completion on a sticky `done`, or an overflow abort on `full`. One instance per scratchpad; its `en`/`done`/`full` are the controller's `en1`/`done1`/`if_full` (or `en2`/`done2`/`filter_full`).

## Interface
Parameters:
- `DATA_W`, 16, stream and scratchpad word width
- `DEPTH`, 16, scratchpad words (power of two, ≥2)
- `ADDR_W`, `$clog2(DEPTH)`, address width (derived)

Ports:
- `clk`  in  1  rising-edge clock (one clock)
- `rst`  in  1  reset; asynchronous, active-high
- `en`  in  1  transfer enable from main controller (level)
- `row_len`  in  ADDR_W+1  words per transfer, sampled at start
- `in_valid`  in  1  stream word present
- `in_data`  in  DATA_W  stream word
- `in_ready`  out  1  stream word accepted when `in_valid & in_ready`
- `rel`  in  1  consumer frees one scratchpad word this cycle
- `wr_en`  out  1  scratchpad write strobe (registered)
- `wr_addr`  out  ADDR_W  scratchpad write address (registered)
- `wr_data`  out  DATA_W (DATA_W+1 with parity)  scratchpad write data (registered)
- `head_addr`  out  ADDR_W  tail pointer latched at transfer start (row head for controller)
- `used`  out  ADDR_W+1  scratchpad occupancy
- `done`  out  1  transfer complete, sticky
- `full`  out  1  overflow abort, sticky

## Operation
- States: IDLE, FILL, DONE, OVF.
- IDLE: `in_ready=0`. On an `en` rising edge (`en & ~en_q`): latch `row_len`, `head_addr<=tail`, `cnt<=0`, clear `done`/`full`, go FILL. Level `en` without an edge does nothing.
- FILL: `in_ready = (used < DEPTH)`.
  - On accept: register `wr_en=1`, `wr_addr=tail`, `wr_data=in_data`. Then `tail<=tail+1 mod DEPTH` and `cnt++`.
  - If the accepted beat is number `row_len` (`cnt==row_len-1`), go DONE and set `done`.
  - If `used==DEPTH & in_valid`, set `full` and go OVF. No write.
  - A latched `row_len==0` goes to DONE on the next cycle with no writes.
- DONE: `in_ready=0`; `done` held. On a new `en` rising edge, restart as from IDLE. Otherwise stay; `en` may remain high while the partner writer finishes.
- OVF: `in_ready=0`; `full` held. When `en` is low, go IDLE. `full` stays set until the next start.
- `en` falling during FILL: abort to IDLE. `tail`/`used` keep the words already written.
- Occupancy, evaluated every cycle in every state: `used <= used + accept - (rel & used!=0)`.
  - Accept and `rel` in the same cycle leave `used` unchanged.
  - `rel` at `used==0` is ignored.
  - `rel` at `used==DEPTH` does not enable a same-cycle accept.
- `tail` and `used` persist across transfers; only `rst` clears them.

## Timing
- Accept in cycle N → `wr_en` high in N+1 with that word's `wr_addr`/`wr_data`. `wr_en` is low in all other cycles.
- Last word: `done` rises in the same cycle as the last `wr_en`.
- `full` rises in the cycle after the refused `in_valid`.
- Back-to-back accepts sustain one word per cycle.
- Start: `en` edge in cycle N → FILL in N+1. The first accept is possible in N+1.
- Reset: all outputs go to 0 immediately and asynchronously (`in_ready`, `wr_en`, `wr_addr`, `wr_data`, `head_addr`, `used`, `done`, `full`). `tail=0`, `en_q=0`, state IDLE. Reset mid-transfer discards the transfer.

## Configuration
- `SPAD_WR_PARITY_EN` defined: `wr_data` is DATA_W+1 bits, and its MSB is the even parity `^in_data` of the accepted word.
- `SPAD_WR_PARITY_EN` not defined: `wr_data` is DATA_W bits, unmodified. All other behaviour is identical.

## Structure
- Package `spad_pkg`: state enum (IDLE, FILL, DONE, OVF), default `DATA_W`/`DEPTH` constants, parity helper function.
- Sub-module `spad_ptr_ctr`: mod-DEPTH tail pointer plus occupancy up/down counter with simultaneous inc/dec handling.
- Top level holds the FSM, the `en` edge detect, the transfer counter and the output registers.

## Test plan
- DEPTH=16, row_len=4, `en` edge, data 0x11,0x22,0x33,0x44 back-to-back → `wr_en` four cycles at addr 0–3, `done=1` with 4th `wr_en`, `used=4`, `in_ready=0` after.
- Follow-up transfer row_len=3 with no `rel` → `head_addr=4`, writes at addr 4,5,6, `used=7`.
- Wrap: tail=14, row_len=4, continuous `rel` → addresses 14,15,0,1, `done=1`, `used` unchanged.
- Overflow: `used=16`, no `rel`, `in_valid=1` → no `wr_en`, `full=1` next cycle, held until `en=0`, then IDLE.
- Accept + `rel` same cycle at `used=5` → `used` stays 5; `rel` at `used=0` → stays 0.
- Assert `rst` after 2 of 4 beats → all outputs 0 immediately; after release, a new `en` edge writes from addr 0.
